rr_arbiter_8to1: RTL

Eight-input round-robin arbiter with registered one-hot grant, built as the stage directly upstream of the 8-to-3 encoder. It samples eight request lines, grants exactly one requester at a time, and holds that grant until release or timeout. Its one-hot `grant` bus is guaranteed single-hot whenever `grant_valid` is high, so the encoder downstream never sees an illegal code.

---
 rtl/arb_pkg.sv | 28 ++
 rtl/rr_pick.sv | 39 +++
 rtl/rr_arbiter_8to1.sv | 116 +++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-input round-robin arbiter.
package arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  typedef logic [N_REQ-1:0] onehot_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Rotate right by sh positions (bit sh lands on bit 0).
  function automatic onehot_t rot_right(input onehot_t v, input idx_t sh);
    logic [2*N_REQ-1:0] dbl;
    dbl = {v, v} >> sh;
    return dbl[N_REQ-1:0];
  endfunction

  // Rotate left by sh positions (bit 0 lands on bit sh).
  function automatic onehot_t rot_left(input onehot_t v, input idx_t sh);
    logic [2*N_REQ-1:0] dbl;
    dbl = {v, v} << sh;
    return dbl[2*N_REQ-1:N_REQ];
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after last+1, wrapping.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] pick_oh,
  output logic [IDX_W-1:0] pick_idx
);

  idx_t    start;
  onehot_t rot;
  onehot_t low_oh;
  idx_t    low_idx;

  // Rotate so the highest-priority requester sits at bit 0.
  always_comb begin
    start = last + idx_t'(1);
    rot   = rot_right(req, start);
  end

  // Isolate the lowest set bit of the rotated vector and find its position.
  always_comb begin
    low_oh  = rot & (~rot + onehot_t'(1));
    low_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        low_idx = idx_t'(i);
      end
    end
  end

  // Rotate back into requester numbering; index arithmetic wraps mod 8.
  always_comb begin
    pick_oh  = rot_left(low_oh, start);
    pick_idx = low_idx + start;
  end

endmodule

// File: rtl/rr_arbiter_8to1.sv
// Eight-input round-robin arbiter with registered one-hot grant, hold limit and
// a guaranteed idle cycle between consecutive grants.
module rr_arbiter_8to1
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic             timeout
);

  localparam cnt_t HoldLast = cnt_t'(MAX_HOLD - 1);

  arb_state_t state_q, state_d;
  idx_t       last_q, last_d;
  idx_t       owner_q, owner_d;
  cnt_t       hold_cnt_q, hold_cnt_d;
  onehot_t    grant_q, grant_d;
  logic       grant_valid_q, grant_valid_d;
  logic       timeout_q, timeout_d;

  onehot_t    pick_oh;
  idx_t       pick_idx;
  logic       early_rel;
  logic       expired;

  rr_pick u_pick (
    .req      (req),
    .last     (last_q),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx)
  );

  // Release causes; done and a dropped request outrank the hold limit for the flag.
  always_comb begin
    early_rel = done | ~req[owner_q];
    expired   = (hold_cnt_q == HoldLast);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    owner_d       = owner_q;
    hold_cnt_d    = hold_cnt_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    timeout_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d       = pick_oh;
          grant_valid_d = 1'b1;
          owner_d       = pick_idx;
          hold_cnt_d    = '0;
          state_d       = GRANT;
        end else begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (early_rel || expired) begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
          last_d        = owner_q;
          hold_cnt_d    = '0;
          timeout_d     = expired & ~early_rel;
          state_d       = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + cnt_t'(1);
        end
      end
      default: begin
        state_d       = IDLE;
        grant_d       = '0;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset puts req[0] at top priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_q        <= idx_t'(N_REQ - 1);
      owner_q       <= '0;
      hold_cnt_q    <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      owner_q       <= owner_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  // Outputs come straight from flops.
  always_comb begin
    grant       = grant_q;
    grant_valid = grant_valid_q;
    timeout     = timeout_q;
  end

endmodule
